// File: rtl/perspective_divide_if.sv
// rtl/perspective_divide_if.sv - valid/ready bundle for the perspective divide stage
// Signal names are from the divider's point of view; the upstream/downstream side uses master.
interface perspective_divide_if #(
  parameter int WIDTH = 32
);
  logic [4*WIDTH-1:0] i_vector;
  logic               i_valid;
  logic               o_ready;
  logic [4*WIDTH-1:0] o_vector;
  logic               o_valid;
  logic               i_ready;
  logic               o_div_by_zero;

  modport slave (
    input  i_vector, i_valid, i_ready,
    output o_ready, o_vector, o_valid, o_div_by_zero
  );

  modport master (
    output i_vector, i_valid, i_ready,
    input  o_ready, o_vector, o_valid, o_div_by_zero
  );
endinterface

// File: rtl/perspective_divide.sv
// rtl/perspective_divide.sv - clip-space to NDC divide {x/w,y/w,z/w,w}
// One shared restoring divider produces one quotient bit per cycle, for x, then y, then z.
module perspective_divide #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  perspective_divide_if.slave  bus
);
  localparam int NB = WIDTH + FRAC;
  localparam int IW = $clog2(NB);
  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_DIV     = 2'd1;
  localparam logic [1:0]       S_DONE    = 2'd2;
  localparam logic [IW-1:0]    ITER_LAST = IW'(NB - 1);
  localparam logic [IW-1:0]    ITER_ONE  = IW'(1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXV      = {1'b0, {(WIDTH-1){1'b1}}};

  logic [1:0]         r_state;
  logic [1:0]         r_comp;
  logic [IW-1:0]      r_iter;
  logic [WIDTH-1:0]   r_x, r_y, r_z, r_w;
  logic [WIDTH-1:0]   r_rem;
  logic [NB-1:0]      r_quo;
  logic [WIDTH-1:0]   r_res_x, r_res_y, r_res_z;
  logic [4*WIDTH-1:0] r_o_vector;
  logic               r_o_valid;
  logic               r_o_dbz;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    f_mag = v[WIDTH-1] ? (~v + ONE) : v;
  endfunction

  function automatic logic [NB-1:0] f_dividend(input logic [WIDTH-1:0] v);
    f_dividend = {f_mag(v), {FRAC{1'b0}}};
  endfunction

  logic [WIDTH-1:0] w_n_cur;
  logic [WIDTH-1:0] w_n_next;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [NB-1:0]    w_q_final;
  logic             w_ovf;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag_res;
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_n_cur  = r_z;
    w_n_next = r_z;
    case (r_comp)
      2'd0: begin w_n_cur = r_x; w_n_next = r_y; end
      2'd1: begin w_n_cur = r_y; w_n_next = r_z; end
      default: begin w_n_cur = r_z; w_n_next = r_z; end
    endcase
  end

  assign w_d       = f_mag(r_w);
  assign w_shift   = {r_rem, r_quo[NB-1]};
  assign w_ge      = (w_shift >= {1'b0, w_d});
  assign w_diff    = w_shift[WIDTH-1:0] - w_d;
  assign w_q_final = {r_quo[NB-2:0], w_ge};
  assign w_ovf     = |w_q_final[NB-1:WIDTH-1];

  // A zero divisor makes the restoring loop emit all ones, so w==0 is resolved by the sign of n.
  always_comb begin
    w_mag_res = '0;
    w_neg     = 1'b0;
    if (r_w == '0) begin
      w_mag_res = (w_n_cur == '0) ? '0 : MAXV;
      w_neg     = w_n_cur[WIDTH-1];
    end else begin
      w_mag_res = w_ovf ? MAXV : {1'b0, w_q_final[WIDTH-2:0]};
      w_neg     = w_n_cur[WIDTH-1] ^ r_w[WIDTH-1];
    end
  end

  assign w_result = w_neg ? (~w_mag_res + ONE) : w_mag_res;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_comp     <= 2'd0;
      r_iter     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_w        <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_res_x    <= '0;
      r_res_y    <= '0;
      r_res_z    <= '0;
      r_o_vector <= '0;
      r_o_valid  <= 1'b0;
      r_o_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_x     <= bus.i_vector[4*WIDTH-1:3*WIDTH];
            r_y     <= bus.i_vector[3*WIDTH-1:2*WIDTH];
            r_z     <= bus.i_vector[2*WIDTH-1:WIDTH];
            r_w     <= bus.i_vector[WIDTH-1:0];
            r_comp  <= 2'd0;
            r_iter  <= '0;
            r_rem   <= '0;
            r_quo   <= f_dividend(bus.i_vector[4*WIDTH-1:3*WIDTH]);
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (r_comp == 2'd3) begin
            r_o_vector <= {r_res_x, r_res_y, r_res_z, r_w};
            r_o_dbz    <= (r_w == '0);
            r_o_valid  <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_iter == ITER_LAST) begin
            case (r_comp)
              2'd0:    r_res_x <= w_result;
              2'd1:    r_res_y <= w_result;
              default: r_res_z <= w_result;
            endcase
            r_comp <= r_comp + 2'd1;
            r_iter <= '0;
            r_rem  <= '0;
            r_quo  <= f_dividend(w_n_next);
          end else begin
            r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_quo  <= w_q_final;
            r_iter <= r_iter + ITER_ONE;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            r_o_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready       = (r_state == S_IDLE);
  assign bus.o_vector      = r_o_vector;
  assign bus.o_valid       = r_o_valid;
  assign bus.o_div_by_zero = r_o_dbz;
endmodule

// File: tb/tb_perspective_divide.sv
// tb/tb_perspective_divide.sv - directed vectors checked against an arithmetic model of x/w, y/w, z/w
module tb_perspective_divide;
  localparam int LAT = 145;
  localparam longint MAXV = 64'sd2147483647;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  perspective_divide_if #(.WIDTH(32)) bif ();

  perspective_divide #(.WIDTH(32), .FRAC(16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_div(input logic [31:0] n, input logic [31:0] w);
    longint sn, sw, q;
    logic [63:0] qb;
    sn = longint'($signed(n));
    sw = longint'($signed(w));
    if (sw == 0) q = (sn > 0) ? MAXV : ((sn < 0) ? -MAXV : 0);
    else q = (sn * 65536) / sw;
    if (q > MAXV) q = MAXV;
    if (q < -MAXV) q = -MAXV;
    qb = q;
    return qb[31:0];
  endfunction

  function automatic logic [127:0] model_vec(input logic [127:0] v);
    return {model_div(v[127:96], v[31:0]), model_div(v[95:64], v[31:0]),
            model_div(v[63:32], v[31:0]), v[31:0]};
  endfunction

  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic [127:0] hold_vec;
  logic         hold_flag;
  logic         prev_valid;
  bit           busy;

  always @(negedge clk) begin
    logic [127:0] v;
    int a;
    if (!rst_n) begin
      chk("reset_o_valid", {127'd0, bif.o_valid}, 128'd0);
      chk("reset_o_vector", bif.o_vector, 128'd0);
      chk("reset_flag", {127'd0, bif.o_div_by_zero}, 128'd0);
      chk("reset_o_ready", {127'd0, bif.o_ready}, 128'd1);
      exp_q.delete();
      acc_q.delete();
      busy = 1'b0;
      hold_vec = '0;
      hold_flag = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk("o_ready", {127'd0, bif.o_ready}, {127'd0, !busy});
      if (bif.o_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_o_valid", {127'd0, bif.o_valid}, 128'd0);
        end else begin
          v = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", 128'(cyc - a), 128'(LAT));
          chk("model_o_vector", bif.o_vector, model_vec(v));
          chk("model_flag", {127'd0, bif.o_div_by_zero}, {127'd0, v[31:0] == 32'd0});
        end
        hold_vec = bif.o_vector;
        hold_flag = bif.o_div_by_zero;
      end else begin
        chk("hold_o_vector", bif.o_vector, hold_vec);
        chk("hold_flag", {127'd0, bif.o_div_by_zero}, {127'd0, hold_flag});
      end
      if (bif.o_valid && bif.i_ready) busy = 1'b0;
      if (bif.i_valid && bif.o_ready) begin
        busy = 1'b1;
        exp_q.push_back(bif.i_vector);
        acc_q.push_back(cyc + 1);
      end
      prev_valid = bif.o_valid;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!bif.o_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_timeout", {127'd0, bif.o_valid}, 128'd1);
  endtask

  task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic [31:0] w, input logic [31:0] ex, input logic [31:0] ey,
                         input logic [31:0] ez, input logic ef, input string name);
    bif.i_vector = {x, y, z, w};
    bif.i_valid = 1'b1;
    @(posedge clk); #1;
    bif.i_valid = 1'b0;
    bif.i_vector = '1;
    wait_valid();
    chk({name, "_vector"}, bif.o_vector, {ex, ey, ez, w});
    chk({name, "_flag"}, {127'd0, bif.o_div_by_zero}, {127'd0, ef});
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bif.i_vector = '0;
    bif.i_valid = 1'b0;
    bif.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("pin_model_half", {96'd0, model_div(32'h00010000, 32'h00020000)}, {96'd0, 32'h00008000});
    chk("pin_model_third", {96'd0, model_div(32'hFFFF0000, 32'h00030000)}, {96'd0, 32'hFFFFAAAB});
    chk("pin_model_sat", {96'd0, model_div(32'h80000000, 32'hFFFF0000)}, {96'd0, 32'h7FFFFFFF});
    chk("pin_model_w0", {96'd0, model_div(32'hFFFF0000, 32'h00000000)}, {96'd0, 32'h80000001});

    run_vec(32'h00010000, 32'hFFFD0000, 32'h00000000, 32'h00020000,
            32'h00008000, 32'hFFFE8000, 32'h00000000, 1'b0, "t1_basic");
    run_vec(32'h00010000, 32'hFFFF0000, 32'h00000001, 32'h00030000,
            32'h00005555, 32'hFFFFAAAB, 32'h00000000, 1'b0, "t2_trunc");
    run_vec(32'h00020000, 32'h00050000, 32'h80000000, 32'hFFFF0000,
            32'hFFFE0000, 32'hFFFB0000, 32'h7FFFFFFF, 1'b0, "t3_negw_sat");
    run_vec(32'h7FFF0000, 32'hFFFF8000, 32'h00000000, 32'h00000100,
            32'h7FFFFFFF, 32'hFF800000, 32'h00000000, 1'b0, "t4_small_w");
    run_vec(32'hFFFF0000, 32'h00000000, 32'h00030000, 32'h00000000,
            32'h80000001, 32'h00000000, 32'h7FFFFFFF, 1'b1, "t4_w_zero");
    run_vec(32'h80000000, 32'h40000000, 32'h00000001, 32'h80000000,
            32'h00010000, 32'hFFFF8000, 32'h00000000, 1'b0, "t_minw");

    // Backpressure with a second vector waiting on i_valid the whole time.
    bif.i_ready = 1'b0;
    bif.i_vector = {32'h00030000, 32'h00000000, 32'hFFFF0000, 32'h00010000};
    bif.i_valid = 1'b1;
    @(posedge clk); #1;
    bif.i_vector = {32'h00010000, 32'h00010000, 32'h00010000, 32'h00040000};
    wait_valid();
    chk("t5_first_vector", bif.o_vector,
        {32'h00030000, 32'h00000000, 32'hFFFF0000, 32'h00010000});
    repeat (20) @(posedge clk);
    #1;
    chk("t5_still_valid", {127'd0, bif.o_valid}, 128'd1);
    chk("t5_still_blocked", {127'd0, bif.o_ready}, 128'd0);
    bif.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_after_hs_valid", {127'd0, bif.o_valid}, 128'd0);
    chk("t5_after_hs_ready", {127'd0, bif.o_ready}, 128'd1);
    @(posedge clk); #1;
    chk("t5_next_accepted", {127'd0, bif.o_ready}, 128'd0);
    bif.i_valid = 1'b0;
    wait_valid();
    chk("t5_second_vector", bif.o_vector,
        {32'h00004000, 32'h00004000, 32'h00004000, 32'h00040000});
    @(posedge clk); #1;

    // Reset in the middle of a divide.
    bif.i_vector = {32'h00070000, 32'h00010000, 32'h00020000, 32'h00020000};
    bif.i_valid = 1'b1;
    @(posedge clk); #1;
    bif.i_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_reset_valid", {127'd0, bif.o_valid}, 128'd0);
    chk("t6_reset_ready", {127'd0, bif.o_ready}, 128'd1);
    chk("t6_reset_vector", bif.o_vector, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("t6_no_output", {127'd0, bif.o_valid}, 128'd0);
    run_vec(32'hFFFE0000, 32'h00070000, 32'h00000000, 32'h00040000,
            32'hFFFF8000, 32'h0001C000, 32'h00000000, 1'b0, "t6_fresh");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
